// File: rtl/scope_framebuffer_pkg.sv
// Shared types and helpers for the scope framebuffer: FSM states, address sizing, range check.
package scope_fb_pkg;

    localparam int COORD_W = 10;
    localparam int RD_LAT  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_state_e;

    // Never returns 0 so degenerate sizes still give a legal vector width.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic coord_oob(input logic [COORD_W-1:0] h,
                                       input logic [COORD_W-1:0] v,
                                       input int                 w,
                                       input int                 hgt);
        return (int'(h) >= w) || (int'(v) >= hgt);
    endfunction

endpackage

// File: rtl/scope_framebuffer_if.sv
// Renderer write port, scan-out read port, clear and swap controls of the scope framebuffer.
interface scope_fb_if #(
    parameter int COLOR_DEPTH = 1
);
    import scope_fb_pkg::*;

    logic                   wr_valid;
    logic                   wr_ready;
    logic [COORD_W-1:0]     wr_h;
    logic [COORD_W-1:0]     wr_v;
    logic [COLOR_DEPTH-1:0] wr_data;
    logic                   rd_en;
    logic [COORD_W-1:0]     rd_h;
    logic [COORD_W-1:0]     rd_v;
    logic [COLOR_DEPTH-1:0] rd_data;
    logic                   rd_valid;
    logic                   clear_req;
    logic [COLOR_DEPTH-1:0] clear_val;
    logic                   clear_busy;
    logic                   clear_done;
    logic                   oob_wr;
    logic                   swap_req;
    logic                   swap_done;

    modport master (
        output wr_valid, wr_h, wr_v, wr_data,
        output rd_en, rd_h, rd_v,
        output clear_req, clear_val, swap_req,
        input  wr_ready, rd_data, rd_valid,
        input  clear_busy, clear_done, oob_wr, swap_done
    );

    modport slave (
        input  wr_valid, wr_h, wr_v, wr_data,
        input  rd_en, rd_h, rd_v,
        input  clear_req, clear_val, swap_req,
        output wr_ready, rd_data, rd_valid,
        output clear_busy, clear_done, oob_wr, swap_done
    );

endinterface

// File: rtl/scope_framebuffer_bank.sv
// One pixel plane: LANES interleaved RAM columns, per-lane write enables, one registered read.
module fb_bank #(
    parameter int CD     = 1,
    parameter int LANES  = 1,
    parameter int NWORDS = 16,
    parameter int WORD_W = 4,
    parameter int LANE_W = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [LANES-1:0]          we_i,
    input  logic [WORD_W-1:0]         waddr_i,
    input  logic [LANES-1:0][CD-1:0]  wdata_i,
    input  logic                      re_i,
    input  logic [WORD_W-1:0]         raddr_i,
    input  logic [LANE_W-1:0]         rlane_i,
    output logic [CD-1:0]             rdata_o
);

    logic [LANES-1:0][CD-1:0] lane_rd;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [CD-1:0] mem [NWORDS];
        logic [CD-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (we_i[l]) mem[waddr_i] <= wdata_i[l];
        end

        // Unselected lanes hold zero so the lane outputs can simply be ORed.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                                  rd_q <= '0;
            else if (re_i && (rlane_i == LANE_W'(l)))    rd_q <= mem[raddr_i];
            else                                         rd_q <= '0;
        end

        assign lane_rd[l] = rd_q;
    end

    always_comb begin
        rdata_o = '0;
        for (int l = 0; l < LANES; l++) rdata_o |= lane_rd[l];
    end

endmodule

// File: rtl/scope_framebuffer.sv
// Scope pixel framebuffer: valid/ready writes, 2-cycle pipelined reads, sweep clear engine.
// Define SCOPE_FB_DOUBLE_BUFFER_EN for front/back banks with a swap request.
module scope_framebuffer
    import scope_fb_pkg::*;
#(
    parameter int COLOR_DEPTH   = 1,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int CLEAR_PER_CYC = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    scope_fb_if.slave fb
);

    localparam int CD     = COLOR_DEPTH;
    localparam int C      = CLEAR_PER_CYC;
    localparam int NPIX   = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int ADDR_W = addr_w(NPIX);
    localparam int NWORDS = NPIX / C;
    localparam int WORD_W = addr_w(NWORDS);
    localparam int LANE_W = addr_w(C);
`ifdef SCOPE_FB_DOUBLE_BUFFER_EN
    localparam int NBANK  = 2;
`else
    localparam int NBANK  = 1;
`endif

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NPIX - C);

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] h,
                                                   input logic [COORD_W-1:0] v);
        return ADDR_W'(v) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(h);
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return WORD_W'(a / ADDR_W'(C));
    endfunction

    function automatic logic [LANE_W-1:0] lane_of(input logic [ADDR_W-1:0] a);
        return LANE_W'(a % ADDR_W'(C));
    endfunction

    fb_state_e         state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [CD-1:0]     clr_val_q;
    logic              wr_ready_q;
    logic              busy_q;
    logic              done_q;
    logic              oob_q;

    logic              wr_fire;
    logic              wr_oob;
    logic [ADDR_W-1:0] wr_addr;
    logic              front_q;
    logic              back_sel;

    assign wr_fire = fb.wr_valid && wr_ready_q;
    assign wr_oob  = coord_oob(fb.wr_h, fb.wr_v, SCREEN_WIDTH, SCREEN_HEIGHT);
    assign wr_addr = pix_addr(fb.wr_h, fb.wr_v);

    // Clear FSM; all status outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            clr_val_q  <= '0;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            oob_q  <= wr_fire && wr_oob;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fb.clear_req) begin
                        state_q    <= CLEAR;
                        ptr_q      <= '0;
                        clr_val_q  <= fb.clear_val;
                        wr_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    ptr_q <= ptr_q + ADDR_W'(C);
                    if (ptr_q == LAST_PTR) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign fb.wr_ready   = wr_ready_q;
    assign fb.clear_busy = busy_q;
    assign fb.clear_done = done_q;
    assign fb.oob_wr     = oob_q;

`ifdef SCOPE_FB_DOUBLE_BUFFER_EN
    logic swap_pend_q;
    logic swap_done_q;
    logic swap_go;

    // Swap lands on the edge that leaves us in IDLE, so a clear always finishes on one bank.
    assign swap_go = (swap_pend_q || fb.swap_req) &&
                     (((state_q == IDLE) && !fb.clear_req) || (state_q == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q     <= 1'b0;
            swap_pend_q <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            swap_done_q <= swap_go;
            if (swap_go) begin
                front_q     <= ~front_q;
                swap_pend_q <= 1'b0;
            end else if (fb.swap_req) begin
                swap_pend_q <= 1'b1;
            end
        end
    end

    assign back_sel     = ~front_q;
    assign fb.swap_done = swap_done_q;
`else
    logic unused_swap;

    assign front_q      = 1'b0;
    assign back_sel     = 1'b0;
    assign fb.swap_done = 1'b0;
    assign unused_swap  = fb.swap_req;
`endif

    // Shared write port: the clear sweep owns it whenever the FSM is in CLEAR.
    logic [C-1:0]         we_lane;
    logic [WORD_W-1:0]    waddr;
    logic [C-1:0][CD-1:0] wdata;

    always_comb begin
        we_lane = '0;
        waddr   = word_of(wr_addr);
        wdata   = {C{fb.wr_data}};
        if (state_q == CLEAR) begin
            we_lane = '1;
            waddr   = word_of(ptr_q);
            wdata   = {C{clr_val_q}};
        end else if (wr_fire && !wr_oob) begin
            we_lane = C'(1) << lane_of(wr_addr);
        end
    end

    // Read stage 1: registered address, range flag and bank select.
    logic [RD_LAT:1]   vld_pipe_q;
    logic [WORD_W-1:0] rd_word_q;
    logic [LANE_W-1:0] rd_lane_q;
    logic              rd_inr_q;
    logic              rd_bank_q;
    logic [ADDR_W-1:0] rd_addr;

    assign rd_addr = pix_addr(fb.rd_h, fb.rd_v);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            rd_word_q  <= '0;
            rd_lane_q  <= '0;
            rd_inr_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[RD_LAT-1:1], fb.rd_en};
            rd_word_q  <= word_of(rd_addr);
            rd_lane_q  <= lane_of(rd_addr);
            rd_inr_q   <= !coord_oob(fb.rd_h, fb.rd_v, SCREEN_WIDTH, SCREEN_HEIGHT);
            rd_bank_q  <= front_q;
        end
    end

    logic [NBANK-1:0][CD-1:0] bank_rdata;

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        fb_bank #(
            .CD     (CD),
            .LANES  (C),
            .NWORDS (NWORDS),
            .WORD_W (WORD_W),
            .LANE_W (LANE_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (we_lane & {C{back_sel == 1'(b)}}),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (vld_pipe_q[1] && rd_inr_q && (rd_bank_q == 1'(b))),
            .raddr_i (rd_word_q),
            .rlane_i (rd_lane_q),
            .rdata_o (bank_rdata[b])
        );
    end

    // Out-of-range and unselected banks read as zero, so an OR picks the live pixel.
    logic [CD-1:0] rd_or;

    always_comb begin
        rd_or = '0;
        for (int b = 0; b < NBANK; b++) rd_or |= bank_rdata[b];
    end

    assign fb.rd_data  = rd_or;
    assign fb.rd_valid = vld_pipe_q[RD_LAT];

endmodule

// File: tb/tb_scope_framebuffer.sv
// Directed bench for scope_framebuffer on a reduced 16x12 plane cleared 4 pixels per cycle.
module tb_scope_framebuffer;
    import scope_fb_pkg::*;

    localparam int W    = 16;
    localparam int H    = 12;
    localparam int C    = 4;
    localparam int NPIX = W * H;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    scope_fb_if #(.COLOR_DEPTH(1)) fb();

    scope_framebuffer #(
        .COLOR_DEPTH   (1),
        .SCREEN_WIDTH  (W),
        .SCREEN_HEIGHT (H),
        .CLEAR_PER_CYC (C)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (fb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr_px(input int h, input int v, input logic d);
        fb.wr_valid = 1'b1;
        fb.wr_h     = 10'(h);
        fb.wr_v     = 10'(v);
        fb.wr_data  = d;
        step();
        fb.wr_valid = 1'b0;
    endtask

    task automatic rd_px(input int h, input int v, input logic exp, input string tag);
        fb.rd_en = 1'b1;
        fb.rd_h  = 10'(h);
        fb.rd_v  = 10'(v);
        step();
        fb.rd_en = 1'b0;
        step();
        chk1({tag, "_valid"}, fb.rd_valid, 1'b1);
        chk1({tag, "_data"}, fb.rd_data, exp);
    endtask

    task automatic run_clear(input logic val, output int busy_n, output int done_n,
                             output int rdy_bad);
        busy_n       = 0;
        done_n       = 0;
        rdy_bad      = 0;
        fb.clear_val = val;
        fb.clear_req = 1'b1;
        step();
        fb.clear_req = 1'b0;
        for (int i = 0; i < 400 && fb.clear_busy; i++) begin
            busy_n++;
            done_n += int'(fb.clear_done);
            if (fb.wr_ready) rdy_bad++;
            step();
        end
        chk1("clear_finished", fb.clear_busy, 1'b0);
    endtask

    initial begin
        int busy_n, done_n, rdy_bad, idle_n;

        rst_n        = 1'b0;
        fb.wr_valid  = 1'b0;
        fb.wr_h      = '0;
        fb.wr_v      = '0;
        fb.wr_data   = '0;
        fb.rd_en     = 1'b0;
        fb.rd_h      = '0;
        fb.rd_v      = '0;
        fb.clear_req = 1'b0;
        fb.clear_val = '0;
        fb.swap_req  = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        chk1("rst_wr_ready", fb.wr_ready, 1'b1);
        chk1("rst_clear_busy", fb.clear_busy, 1'b0);
        chk1("rst_clear_done", fb.clear_done, 1'b0);
        chk1("rst_oob_wr", fb.oob_wr, 1'b0);
        chk1("rst_rd_valid", fb.rd_valid, 1'b0);
        chk1("rst_rd_data", fb.rd_data, 1'b0);
        chk1("rst_swap_done", fb.swap_done, 1'b0);

`ifndef SCOPE_FB_DOUBLE_BUFFER_EN
        // Write then read back with exact two-cycle latency.
        wr_px(3, 2, 1'b1);
        chk1("t1_no_oob", fb.oob_wr, 1'b0);
        fb.rd_en = 1'b1;
        fb.rd_h  = 10'd3;
        fb.rd_v  = 10'd2;
        step();
        fb.rd_en = 1'b0;
        chk1("t1_valid_early", fb.rd_valid, 1'b0);
        step();
        chk1("t1_valid", fb.rd_valid, 1'b1);
        chk1("t1_data", fb.rd_data, 1'b1);
        step();
        chk1("t1_valid_drop", fb.rd_valid, 1'b0);

        // Full clear to 1: busy window, wr_ready low, single done pulse, whole plane reads 1.
        run_clear(1'b1, busy_n, done_n, rdy_bad);
        chkn("t3_busy_cycles", busy_n, NPIX / C + 1);
        chkn("t3_done_pulses", done_n, 1);
        chkn("t3_wr_ready_low", rdy_bad, 0);
        chk1("t3_wr_ready_back", fb.wr_ready, 1'b1);
        for (int i = 0; i <= NPIX; i++) begin
            fb.rd_en = (i < NPIX);
            fb.rd_h  = 10'(i % W);
            fb.rd_v  = 10'(i / W);
            step();
            if (i >= 1) begin
                chk1("t3_sweep_valid", fb.rd_valid, 1'b1);
                chk1("t3_sweep_data", fb.rd_data, 1'b1);
            end
        end
        fb.rd_en = 1'b0;

        // Out-of-range writes are accepted but leave RAM alone; out-of-range reads give 0.
        wr_px(W, 0, 1'b0);
        chk1("t2_oob_h_pulse", fb.oob_wr, 1'b1);
        step();
        chk1("t2_oob_h_clear", fb.oob_wr, 1'b0);
        wr_px(0, H, 1'b0);
        chk1("t2_oob_v_pulse", fb.oob_wr, 1'b1);
        rd_px(0, 1, 1'b1, "t2_alias_kept");
        rd_px(W - 1, H - 1, 1'b1, "t2_last_kept");
        rd_px(0, H, 1'b0, "t2_oob_rd_v");
        rd_px(W, 0, 1'b0, "t2_oob_rd_h");

        // Write and clear_req on the same edge: the clear wins.
        chk1("t4_ready_before", fb.wr_ready, 1'b1);
        fb.wr_valid  = 1'b1;
        fb.wr_h      = 10'd5;
        fb.wr_v      = 10'd5;
        fb.wr_data   = 1'b1;
        fb.clear_val = 1'b0;
        fb.clear_req = 1'b1;
        step();
        fb.wr_valid  = 1'b0;
        fb.clear_req = 1'b0;
        chk1("t4_busy", fb.clear_busy, 1'b1);
        done_n = 0;
        for (int i = 0; i < 400 && fb.clear_busy; i++) begin
            done_n += int'(fb.clear_done);
            step();
        end
        chkn("t4_done_pulses", done_n, 1);
        rd_px(5, 5, 1'b0, "t4_px55");
        rd_px(0, 0, 1'b0, "t4_px00");

        // clear_req held: two back-to-back clears with a single IDLE cycle between.
        fb.clear_val = 1'b0;
        fb.clear_req = 1'b1;
        step();
        done_n = 0;
        idle_n = 0;
        for (int k = 1; k <= 2 * (NPIX / C) + 2; k++) begin
            step();
            done_n += int'(fb.clear_done);
            if (!fb.clear_busy) idle_n++;
        end
        fb.clear_req = 1'b0;
        chkn("b2b_done_pulses", done_n, 2);
        chkn("b2b_idle_gap", idle_n, 1);
        step();
        chk1("b2b_idle_after", fb.clear_busy, 1'b0);
        step();
        chk1("b2b_no_third", fb.clear_busy, 1'b0);

        // Reset mid-clear at ptr=20: pixels below 20 cleared, the rest untouched.
        fb.clear_val = 1'b1;
        fb.clear_req = 1'b1;
        step();
        fb.clear_req = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        chk1("t5_busy_reset", fb.clear_busy, 1'b0);
        chk1("t5_ready_reset", fb.wr_ready, 1'b1);
        step();
        rst_n  = 1'b1;
        done_n = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            done_n += int'(fb.clear_done);
        end
        chkn("t5_no_done", done_n, 0);
        chk1("t5_idle", fb.clear_busy, 1'b0);
        rd_px(3, 1, 1'b1, "t5_px19");
        rd_px(4, 1, 1'b0, "t5_px20");
        rd_px(5, 1, 1'b0, "t5_px21");
        rd_px(0, 0, 1'b1, "t5_px0");

        // Single bank build ignores swap_req.
        fb.swap_req = 1'b1;
        step();
        fb.swap_req = 1'b0;
        chk1("swap_ignored0", fb.swap_done, 1'b0);
        step();
        chk1("swap_ignored1", fb.swap_done, 1'b0);
`else
        // Zero both banks so the front plane has a known value.
        run_clear(1'b0, busy_n, done_n, rdy_bad);
        chkn("db_clear_a", busy_n, NPIX / C + 1);
        fb.swap_req = 1'b1;
        step();
        fb.swap_req = 1'b0;
        chk1("db_swap_init", fb.swap_done, 1'b1);
        run_clear(1'b0, busy_n, done_n, rdy_bad);
        chkn("db_clear_b", done_n, 1);

        wr_px(1, 1, 1'b1);
        rd_px(1, 1, 1'b0, "db_front_old");
        fb.swap_req = 1'b1;
        step();
        fb.swap_req = 1'b0;
        chk1("db_swap_done", fb.swap_done, 1'b1);
        step();
        chk1("db_swap_pulse_end", fb.swap_done, 1'b0);
        rd_px(1, 1, 1'b1, "db_front_new");

        // Swap requested mid-clear waits until the clear completes.
        fb.clear_val = 1'b1;
        fb.clear_req = 1'b1;
        step();
        fb.clear_req = 1'b0;
        fb.swap_req  = 1'b1;
        step();
        fb.swap_req  = 1'b0;
        chk1("db_swap_deferred", fb.swap_done, 1'b0);
        for (int i = 0; i < 400 && !fb.clear_done; i++) step();
        chk1("db_clear_done_seen", fb.clear_done, 1'b1);
        chk1("db_swap_not_yet", fb.swap_done, 1'b0);
        step();
        chk1("db_swap_after_done", fb.swap_done, 1'b1);
        rd_px(0, 0, 1'b1, "db_cleared_front");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
